// File: rtl/ysyx_22041461_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_pkg
//   Shared constants and types for the pipelined NPC general-purpose
//   register file.
//   XLEN : architectural register width
//   NREG : number of architectural registers (x0 hard-wired to zero)
//   NRD  : default number of read ports
//   NWR  : default number of write ports
//   AW   : register address width
// ---------------------------------------------------------------------------
package ysyx_22041461_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   gpr_addr_t;
    typedef logic [XLEN-1:0] gpr_data_t;

endpackage

// File: rtl/ysyx_22041461_gpr_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_gpr_scoreboard
//   Busy-bit scoreboard for RAW/WAW hazard detection. One busy bit per
//   architectural register marks an outstanding producer.
//   Ports:
//     clk, rst   : clock (rising edge), asynchronous active-low reset
//     rd_addr    : read-port addresses, port k at [k*AW +: AW]
//     rd_busy    : per read port, addressed register still has a producer
//     wr_en/addr : writeback ports; a write clears the target busy bit
//     iss_valid  : decode issues an instruction writing iss_rd
//     iss_rd     : destination register of the issuing instruction
//     iss_ready  : issue may be accepted this cycle
//     flush      : clear every busy bit, ignore this cycle's issue
//     busy_cnt   : number of busy registers
// ---------------------------------------------------------------------------
module ysyx_22041461_gpr_scoreboard #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);
    import ysyx_22041461_pkg::*;

    localparam int CW = AW + 1;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clear_now;
    logic [CW-1:0]   busy_cnt_q;
    logic [CW-1:0]   busy_cnt_d;
    logic            accept;

    // Registers being written back this cycle. Bit 0 may be set by a write
    // to x0; every consumer masks x0 separately.
    always_comb begin
        clear_now = '0;
        for (int r = 0; r < NREG; r++) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
                    clear_now[r] = 1'b1;
                end
            end
        end
    end

    // A same-cycle writeback of the destination releases a WAW stall.
    assign iss_ready = (iss_rd == '0) | ~busy_q[iss_rd] | clear_now[iss_rd];
    assign accept    = iss_valid & iss_ready & ~flush;

    // Clears are applied first so that a new producer issued in the same
    // cycle as the old producer's writeback stays outstanding.
    always_comb begin
        busy_d = busy_q & ~clear_now;
        if (flush) begin
            busy_d = '0;
        end else if (accept && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_busy
            logic [AW-1:0] addr;
            assign addr        = rd_addr[gi*AW +: AW];
            assign rd_busy[gi] = (addr != '0) & busy_q[addr] & ~clear_now[addr];
        end
    endgenerate

endmodule

// File: rtl/ysyx_22041461_gpr_file.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_gpr_file
//   Multi-ported general-purpose register file with write-to-read bypass
//   and a busy-bit scoreboard. Sits between decode and writeback.
//   Ports:
//     clk, rst   : clock (rising edge), asynchronous active-low reset
//     rd_addr    : read addresses, port k at [k*AW +: AW]
//     rd_data    : bypassed read data, port k at [k*XLEN +: XLEN]
//     rd_busy    : addressed register has a pending producer
//     wr_en      : write enables, higher port index has priority
//     wr_addr    : write addresses
//     wr_data    : write data
//     iss_valid  : decode issues an instruction writing iss_rd
//     iss_rd     : destination of the issuing instruction
//     iss_ready  : issue may be accepted
//     flush      : clear all busy bits
//     busy_cnt   : number of busy registers
//     dbg_addr   : debug read address
//     dbg_data   : architectural value of x[dbg_addr], never bypassed
// ---------------------------------------------------------------------------
module ysyx_22041461_gpr_file #(
    parameter int XLEN = ysyx_22041461_pkg::XLEN,
    parameter int NREG = ysyx_22041461_pkg::NREG,
    parameter int NRD  = ysyx_22041461_pkg::NRD,
    parameter int NWR  = ysyx_22041461_pkg::NWR,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    import ysyx_22041461_pkg::*;

    logic [XLEN-1:0] gpr_q [NREG];
    logic [XLEN-1:0] gpr_d [NREG];

    // Ports are scanned in ascending order so the highest-index port
    // writing a register is the one that lands. x0 is never updated.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            gpr_d[r] = gpr_q[r];
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
                    gpr_d[r] = wr_data[p*XLEN +: XLEN];
                end
            end
        end
        gpr_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                gpr_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                gpr_q[r] <= gpr_d[r];
            end
        end
    end

    // Read ports: x0 forced to zero, otherwise the highest-priority
    // same-cycle write to the address is forwarded.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_port
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] word;

            assign addr = rd_addr[gi*AW +: AW];

            always_comb begin
                word = gpr_q[addr];
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
                        word = wr_data[p*XLEN +: XLEN];
                    end
                end
                if (addr == '0) begin
                    word = '0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = word;
        end
    endgenerate

    assign dbg_data = gpr_q[dbg_addr];

    ysyx_22041461_gpr_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_ysyx_22041461_gpr_file.sv
module tb_ysyx_22041461_gpr_file;
    import ysyx_22041461_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         iss_valid;
    gpr_addr_t    iss_rd;
    logic         iss_ready;
    logic         flush;
    logic [5:0]   busy_cnt;
    gpr_addr_t    dbg_addr;
    gpr_data_t    dbg_data;

    int checks   = 0;
    int failures = 0;

    ysyx_22041461_gpr_file dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    // mask bits: 0 rd0, 1 rd1, 2 rd_busy, 3 busy_cnt, 4 iss_ready, 5 dbg
    typedef struct {
        logic [127:0] tag;
        logic [5:0]   mask;
        gpr_data_t    rd0;
        gpr_data_t    rd1;
        logic [1:0]   busy;
        logic [5:0]   cnt;
        logic         rdy;
        gpr_data_t    dbg;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model for random traffic ----------------
    gpr_data_t   m_x [32];
    logic [31:0] m_busy;

    function automatic logic hit(input int p, input gpr_addr_t a);
        return wr_en[p] && (wr_addr[p*5 +: 5] == a);
    endfunction

    function automatic gpr_data_t m_read(input gpr_addr_t a);
        gpr_data_t v;
        if (a == 5'd0) return 64'd0;
        v = m_x[a];
        if (hit(0, a)) v = wr_data[63:0];
        if (hit(1, a)) v = wr_data[127:64];
        return v;
    endfunction

    function automatic logic m_clear(input gpr_addr_t a);
        return hit(0, a) || hit(1, a);
    endfunction

    function automatic logic m_rdbusy(input gpr_addr_t a);
        return (a != 5'd0) && m_busy[a] && !m_clear(a);
    endfunction

    function automatic logic [5:0] m_cnt();
        logic [5:0] c = 6'd0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c = c + 6'd1;
        return c;
    endfunction

    function automatic logic m_ready();
        return (iss_rd == 5'd0) || !m_busy[iss_rd] || m_clear(iss_rd);
    endfunction

    task automatic m_update();
        logic acc;
        gpr_addr_t a;
        acc = iss_valid && m_ready();
        for (int p = 0; p < 2; p++) begin
            a = wr_addr[p*5 +: 5];
            if (wr_en[p] && a != 5'd0) begin
                m_x[a]    = wr_data[p*64 +: 64];
                m_busy[a] = 1'b0;
            end
        end
        if (flush) m_busy = 32'd0;
        else if (acc && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input logic [127:0] tag, input string f,
                       input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %0s.%0s actual=0x%0h expected=0x%0h", tag, f, act, expv);
        end
    endtask

    task automatic idle();
        wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        rd_addr = '0; dbg_addr = '0;
    endtask

    task automatic push(input logic [127:0] tag, input logic [5:0] mask,
                        input gpr_data_t rd0, input gpr_data_t rd1,
                        input logic [1:0] busy, input logic [5:0] cnt,
                        input logic rdy, input gpr_data_t dbg);
        exp_t e;
        e.tag = tag; e.mask = mask; e.rd0 = rd0; e.rd1 = rd1;
        e.busy = busy; e.cnt = cnt; e.rdy = rdy; e.dbg = dbg;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.mask[0]) chk(e.tag, "rd0", rd_data[63:0], e.rd0);
            if (e.mask[1]) chk(e.tag, "rd1", rd_data[127:64], e.rd1);
            if (e.mask[2]) chk(e.tag, "rd_busy", 64'(rd_busy), 64'(e.busy));
            if (e.mask[3]) chk(e.tag, "busy_cnt", 64'(busy_cnt), 64'(e.cnt));
            if (e.mask[4]) chk(e.tag, "iss_ready", 64'(iss_ready), 64'(e.rdy));
            if (e.mask[5]) chk(e.tag, "dbg", dbg_data, e.dbg);
            $display("txn %0s rd0=%h rd1=%h busy=%b cnt=%0d rdy=%b dbg=%h",
                     e.tag, rd_data[63:0], rd_data[127:64], rd_busy, busy_cnt, iss_ready, dbg_data);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        idle();
        tick();

        // reset state
        rd_addr = {5'd0, 5'd5};
        push("reset", 6'h3F, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();
        rst = 1'b1;

        // two ports writing x3: port 1 wins, also visible through bypass
        idle();
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3};
        wr_data = {64'h5555, 64'hAAAA}; rd_addr = {5'd0, 5'd3};
        push("t2_bypass", 6'h1F, 64'h5555, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();
        idle();
        rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3;
        push("t2_commit", 6'h3F, 64'h5555, 64'd0, 2'b00, 6'd0, 1'b1, 64'h5555);
        tick();

        // x0 write ignored, issue of rd=0 never sets busy
        idle();
        wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {64'hFFFF, 64'd0};
        iss_valid = 1'b1; iss_rd = 5'd0;
        push("t3_x0_wr", 6'h3F, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();
        idle();
        push("t3_x0_after", 6'h3F, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();

        // issue x7, stall on re-issue, WAW release by same-cycle writeback
        idle();
        iss_valid = 1'b1; iss_rd = 5'd7; rd_addr = {5'd0, 5'd7};
        push("t4_issue", 6'h1D, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd7; rd_addr = {5'd0, 5'd7};
        push("t4_stall", 6'h1C, 64'd0, 64'd0, 2'b01, 6'd1, 1'b0, 64'd0);
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd7; rd_addr = {5'd0, 5'd7};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {64'd0, 64'h77};
        push("t4_waw_rel", 6'h1D, 64'h77, 64'd0, 2'b00, 6'd1, 1'b1, 64'd0);
        tick();
        idle();
        rd_addr = {5'd0, 5'd7}; dbg_addr = 5'd7;
        push("t4_after", 6'h3D, 64'h77, 64'd0, 2'b01, 6'd1, 1'b1, 64'h77);
        tick();

        // three issues then flush with a simultaneous issue and write
        idle(); iss_valid = 1'b1; iss_rd = 5'd9;
        push("t5_iss9", 6'h18, 64'd0, 64'd0, 2'b00, 6'd1, 1'b1, 64'd0);
        tick();
        idle(); iss_valid = 1'b1; iss_rd = 5'd10;
        push("t5_iss10", 6'h18, 64'd0, 64'd0, 2'b00, 6'd2, 1'b1, 64'd0);
        tick();
        idle(); iss_valid = 1'b1; iss_rd = 5'd11;
        push("t5_iss11", 6'h18, 64'd0, 64'd0, 2'b00, 6'd3, 1'b1, 64'd0);
        tick();
        idle();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd12;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {64'd0, 64'h99};
        rd_addr = {5'd9, 5'd12};
        push("t5_flush", 6'h1F, 64'd0, 64'h99, 2'b00, 6'd4, 1'b1, 64'd0);
        tick();
        idle();
        rd_addr = {5'd9, 5'd12}; dbg_addr = 5'd9; iss_rd = 5'd12;
        push("t5_after", 6'h3F, 64'd0, 64'h99, 2'b00, 6'd0, 1'b1, 64'h99);
        tick();

        // reset while x5 is busy
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'd0, 64'h1234};
        iss_valid = 1'b1; iss_rd = 5'd5; rd_addr = {5'd0, 5'd5};
        push("t1_set", 6'h1D, 64'h1234, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();
        idle();
        iss_rd = 5'd5; rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
        push("t1_busy", 6'h3D, 64'h1234, 64'd0, 2'b01, 6'd1, 1'b0, 64'h1234);
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd5; rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
        rst = 1'b0;
        push("t1_reset", 6'h3D, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();
        rst = 1'b1;
        idle();
        iss_rd = 5'd5; rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
        push("t1_after", 6'h3D, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 64'd0);
        tick();

        // random traffic against the reference model, starting from reset state
        for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
        m_busy = 32'd0;
        for (int n = 0; n < 10000; n++) begin
            for (int p = 0; p < 2; p++) begin
                wr_en[p] = ($urandom_range(0, 2) == 0);
                wr_addr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                                : 5'($urandom_range(0, 7));
                wr_data[p*64 +: 64] = {$urandom, $urandom};
                rd_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_rd    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 31) == 0);
            dbg_addr  = 5'($urandom_range(0, 7));
            push("rnd", 6'h3F, m_read(rd_addr[4:0]), m_read(rd_addr[9:5]),
                 {m_rdbusy(rd_addr[9:5]), m_rdbusy(rd_addr[4:0])},
                 m_cnt(), m_ready(), m_x[dbg_addr]);
            m_update();
            tick();
        end
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
